// File: rtl/wash_program_sequencer.sv
// Program-level washing-machine sequencer.
// It latches the selected program on start and walks the phase plan FILL, WASH,
// RINSE, SPIN and DRY, with a seconds countdown for each phase.
// Pause and an open door freeze the countdown; stop aborts to IDLE.
// All outputs are decoded from registers only.
`timescale 1ns/1ps
module wash_program_sequencer #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int FILL_SECS   = 7,
  parameter int WASH_SECS   = 5,
  parameter int RINSE_SECS  = 5,
  parameter int SPIN_SECS   = 10,
  parameter int DRY_SECS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       door_closed,
  input  logic [1:0] prog,
  output logic [2:0] phase,
  output logic [7:0] secs_left,
  output logic       valve_on,
  output logic       motor_on,
  output logic       spin_on,
  output logic       heater_on,
  output logic       door_lock,
  output logic       busy,
  output logic       paused,
  output logic       done
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DRY   = 3'd5
  } phase_t;

  phase_t        phase_q, phase_n, end_next;
  logic [7:0]    secs_q, secs_n;
  logic [PW-1:0] presc_q, presc_n;
  logic [1:0]    wash_cnt_q, wash_cnt_n;
  logic [1:0]    prog_q, prog_n;
  logic          paused_q, paused_n;
  logic          door_open_q, door_open_n;
  logic          done_q, done_n;
  logic          tick;

  function automatic logic [7:0] phase_secs(input phase_t p);
    case (p)
      FILL:    return 8'(FILL_SECS);
      WASH:    return 8'(WASH_SECS);
      RINSE:   return 8'(RINSE_SECS);
      SPIN:    return 8'(SPIN_SECS);
      DRY:     return 8'(DRY_SECS);
      default: return 8'd0;
    endcase
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  // Choose the phase that follows the current one once its countdown expires.
  always_comb begin
    end_next = IDLE;
    case (phase_q)
      FILL:    end_next = WASH;
      WASH:    end_next = RINSE;
      RINSE:   end_next = (prog_q == 2'd1 && wash_cnt_q == 2'd1) ? WASH : SPIN;
      SPIN:    end_next = (prog_q == 2'd2 || prog_q == 2'd3) ? DRY : IDLE;
      default: end_next = IDLE;
    endcase
  end

  // Next-state logic: start acceptance, stop abort, prescaler and countdown.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the logic infers a latch.
    phase_n    = phase_q;
    secs_n     = secs_q;
    presc_n    = presc_q;
    wash_cnt_n = wash_cnt_q;
    prog_n     = prog_q;
    done_n     = 1'b0;
    case (phase_q)
      IDLE: begin
        secs_n     = 8'd0;
        presc_n    = '0;
        wash_cnt_n = 2'd0;
        if (start && !stop && door_closed) begin
          prog_n  = prog;
          phase_n = (prog == 2'd2) ? SPIN : FILL;
          secs_n  = (prog == 2'd2) ? phase_secs(SPIN) : phase_secs(FILL);
        end
      end
      FILL, WASH, RINSE, SPIN, DRY: begin
        if (stop) begin
          phase_n = IDLE;
          secs_n  = 8'd0;
          presc_n = '0;
        end else if (!paused_q) begin
          if (tick) begin
            presc_n = '0;
            if (secs_q == 8'd1) begin
              phase_n = end_next;
              secs_n  = phase_secs(end_next);
              done_n  = (end_next == IDLE);
              if (phase_q == WASH) wash_cnt_n = wash_cnt_q + 2'd1;
            end else begin
              secs_n = secs_q - 8'd1;
            end
          end else begin
            presc_n = presc_q + PW'(1);
          end
        end
      end
      default: begin
        phase_n = IDLE;
        secs_n  = 8'd0;
        presc_n = '0;
      end
    endcase
    paused_n    = (phase_n != IDLE) && (pause || !door_closed);
    door_open_n = !door_closed;
  end

  // State register; reset aborts any program immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= IDLE;
      secs_q      <= 8'd0;
      presc_q     <= '0;
      wash_cnt_q  <= 2'd0;
      prog_q      <= 2'd0;
      paused_q    <= 1'b0;
      door_open_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      phase_q     <= phase_n;
      secs_q      <= secs_n;
      presc_q     <= presc_n;
      wash_cnt_q  <= wash_cnt_n;
      prog_q      <= prog_n;
      paused_q    <= paused_n;
      door_open_q <= door_open_n;
      done_q      <= done_n;
    end
  end

  assign phase     = phase_q;
  assign secs_left = secs_q;
  assign busy      = (phase_q != IDLE);
  assign paused    = paused_q;
  assign done      = done_q;
  assign valve_on  = (phase_q == FILL) && !paused_q;
  assign motor_on  = (phase_q == WASH || phase_q == RINSE) && !paused_q;
  assign spin_on   = (phase_q == SPIN) && !paused_q;
  assign heater_on = (phase_q == DRY) && !paused_q;
  assign door_lock = busy && !door_open_q;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Self-checking bench for wash_program_sequencer.
// A plan-queue reference model counts down the remaining cycles of each phase
// and is compared against the DUT after every clock edge.
`timescale 1ns/1ps
module tb_wash_program_sequencer;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, door_closed;
  logic [1:0] prog;
  logic [2:0] phase;
  logic [7:0] secs_left;
  logic       valve_on, motor_on, spin_on, heater_on, door_lock, busy, paused, done;

  int total = 0;
  int bad   = 0;

  // Reference model state: current phase, unpaused cycles left in it, remaining plan.
  int m_phase;
  int m_rem;
  int m_plan[$];
  bit m_paused, m_door_open, m_done;

  wash_program_sequencer #(.CLK_PER_SEC(CPS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .door_closed(door_closed), .prog(prog), .phase(phase), .secs_left(secs_left),
    .valve_on(valve_on), .motor_on(motor_on), .spin_on(spin_on), .heater_on(heater_on),
    .door_lock(door_lock), .busy(busy), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_cycles(input int p);
    case (p)
      1:       return 7 * CPS;
      2, 3:    return 5 * CPS;
      4, 5:    return 10 * CPS;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_rem = 0;
    m_plan.delete();
    m_paused = 0;
    m_door_open = 0;
    m_done = 0;
  endtask

  task automatic model_edge(input bit s, input bit st, input bit pa, input bit dc,
                            input logic [1:0] pg);
    m_done = 0;
    if (m_phase == 0) begin
      if (s && !st && dc) begin
        case (pg)
          2'd0:    m_plan = '{1, 2, 3, 4};
          2'd1:    m_plan = '{1, 2, 3, 2, 3, 4};
          2'd2:    m_plan = '{4, 5};
          default: m_plan = '{1, 2, 3, 4, 5};
        endcase
        m_phase = m_plan.pop_front();
        m_rem = dur_cycles(m_phase);
      end
    end else if (st) begin
      m_phase = 0;
      m_rem = 0;
      m_plan.delete();
    end else if (!m_paused) begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_plan.size() == 0) begin
          m_phase = 0;
          m_done = 1;
        end else begin
          m_phase = m_plan.pop_front();
          m_rem = dur_cycles(m_phase);
        end
      end
    end
    m_paused = (m_phase != 0) && (pa || !dc);
    m_door_open = !dc;
  endtask

  function automatic logic [18:0] exp_vec();
    logic [7:0] s;
    bit run;
    s = (m_phase == 0) ? 8'd0 : 8'((m_rem + CPS - 1) / CPS);
    run = !m_paused;
    return {3'(m_phase), s, m_phase == 1 && run, (m_phase == 2 || m_phase == 3) && run,
            m_phase == 4 && run, m_phase == 5 && run, m_phase != 0 && !m_door_open,
            m_phase != 0, m_paused, m_done};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {phase, secs_left, valve_on, motor_on, spin_on, heater_on,
            door_lock, busy, paused, done};
  endfunction

  task automatic step(input bit s, input bit st, input bit pa, input bit dc,
                      input logic [1:0] pg);
    start = s;
    stop = st;
    pause = pa;
    door_closed = dc;
    prog = pg;
    @(posedge clk);
    model_edge(s, st, pa, dc, pg);
    #1;
    check("outs", dut_vec(), exp_vec());
  endtask

  // Running step with a wandering prog input, which must not affect a latched program.
  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
  endtask

  task automatic run_prog(input logic [1:0] pg, input int exp_len, output bit valve_seen);
    int n;
    step(1'b1, 1'b0, 1'b0, 1'b1, pg);
    check("entry_phase", phase, (pg == 2'd2) ? 4 : 1);
    n = 0;
    valve_seen = 0;
    while (done !== 1'b1 && n < 400) begin
      idle_step();
      n++;
      if (valve_on) valve_seen = 1;
    end
    check("done_at", n, exp_len);
  endtask

  initial begin
    bit vs;
    bit reached;
    int n;

    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    door_closed = 1'b1;
    prog = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_vec(), exp_vec());
    @(negedge clk);
    rst = 1'b0;

    // Whole programs: done latency counted from the start edge.
    run_prog(2'd0, 108, vs);
    run_prog(2'd1, 148, vs);
    run_prog(2'd2, 80, vs);
    check("valve_in_prog2", vs, 0);
    run_prog(2'd3, 148, vs);

    // Pause for 17 cycles in WASH at the start of its secs_left=3 second.
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    n = 0;
    while (!(m_phase == 2 && m_rem == 3 * CPS) && n < 200) begin
      idle_step();
      n++;
    end
    reached = (phase == 3'd2 && secs_left == 8'd3);
    check("reach_wash3", reached, 1);
    for (int k = 0; k < 17; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
      n++;
      check("pause_secs", secs_left, 3);
      check("pause_motor", motor_on, 0);
      check("pause_lock", door_lock, 1);
    end
    while (done !== 1'b1 && n < 600) begin
      idle_step();
      n++;
    end
    check("pause_done_at", n, 108 + 17);

    // Door opened mid-RINSE, with start requests while it is open.
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    n = 0;
    while (phase !== 3'd3 && n < 200) begin
      idle_step();
      n++;
    end
    repeat (5) idle_step();
    check("reach_rinse", phase, 3);
    for (int k = 0; k < 6; k++) begin
      step(k == 2 || k == 4, 1'b0, 1'b0, 1'b0, 2'd2);
      check("door_paused", paused, 1);
      check("door_unlock", door_lock, 0);
      check("door_motor", motor_on, 0);
      check("door_phase", phase, 3);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    check("resume_paused", paused, 0);
    check("resume_motor", motor_on, 1);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      idle_step();
      n++;
    end
    check("door_done_seen", done, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("idle_door_open_start", phase, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    check("idle_start_stop", phase, 0);

    // Stop coinciding with the final SPIN tick.
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    n = 0;
    while (!(m_phase == 4 && m_rem == 1) && n < 300) begin
      idle_step();
      n++;
    end
    reached = (phase == 3'd4 && secs_left == 8'd1);
    check("reach_last_spin", reached, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    check("stop_phase", phase, 0);
    check("stop_done", done, 0);
    idle_step();
    check("stop_done_after", done, 0);

    // Asynchronous reset mid-FILL, then a fresh program.
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    repeat (10) idle_step();
    check("rst_pre_fill", phase, 1);
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", dut_vec(), exp_vec());
    @(negedge clk);
    rst = 1'b0;
    run_prog(2'd0, 108, vs);

    // Random front-panel activity checked cycle by cycle.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 255) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 31) != 0,
           2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_program_sequencer.md
Name: wash_program_sequencer

Overview:
Program-level controller for the washing-machine datapath. It latches a user-selected wash program and steps through the fill, wash, rinse, spin and dry phases with per-phase second-based timers. It drives the actuator enables (valve, motor, spin, heater, door lock) and handles pause, stop and the door interlock. It sits between the front-panel inputs and the actuator drivers and replaces ad-hoc per-phase sequencing.

Parameters:
CLK_PER_SEC, 50000000, clk cycles per 1-second tick (benches use 4)
FILL_SECS, 7, fill phase duration in seconds
WASH_SECS, 5, wash phase duration in seconds
RINSE_SECS, 5, rinse phase duration in seconds
SPIN_SECS, 10, spin phase duration in seconds
DRY_SECS, 10, dry phase duration in seconds

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  start request; level, sampled every cycle
stop  in  1  abort request; level
pause  in  1  pause request; level, held high to stay paused
door_closed  in  1  door sensor, 1 = closed
prog  in  2  program: 0 normal, 1 double wash, 2 spin+dry only, 3 normal+dry
phase  out  3  current phase: 0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DRY
secs_left  out  8  seconds remaining in the current phase; 0 in IDLE
valve_on  out  1  water inlet valve
motor_on  out  1  drum agitation (WASH, RINSE)
spin_on  out  1  high-speed spin (SPIN)
heater_on  out  1  dryer heater (DRY)
door_lock  out  1  door lock solenoid
busy  out  1  high whenever phase != IDLE
paused  out  1  high while the program is frozen
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: phase=IDLE, secs_left=0, all actuator outputs 0, door_lock=0, busy=0, paused=0, done=0. Internal counters are cleared. Reset mid-program aborts immediately.
- Start: accepted only in IDLE when start=1, stop=0 and door_closed=1. prog is latched on acceptance. Later changes to prog have no effect until the next start. start while busy is ignored.
- First phase: prog 0, 1 and 3 begin in FILL. Prog 2 begins in SPIN. The entry takes effect the cycle after acceptance.
- Phase entry: secs_left loads the phase duration and the prescaler clears to 0.
- Tick generation: the prescaler counts 0..CLK_PER_SEC-1 while running and not paused. A tick is issued in the cycle where prescaler=CLK_PER_SEC-1. Each tick decrements secs_left.
- Phase timing: a tick with secs_left==1 ends the phase. Each phase therefore lasts exactly DUR*CLK_PER_SEC unpaused cycles.
- Transitions:
  - FILL -> WASH.
  - WASH -> RINSE.
  - RINSE -> WASH if prog=1 and wash_count==1, else SPIN.
  - SPIN -> DRY if prog is 2 or 3, else IDLE.
  - DRY -> IDLE.
- Wash counter: wash_count (2 bits) clears in IDLE and increments at the end of each WASH phase.
- Completion: on the transition into IDLE from the final phase, done=1 for exactly the first IDLE cycle.
- Actuator map: valve_on in FILL; motor_on in WASH and RINSE; spin_on in SPIN; heater_on in DRY. door_lock=busy.
- Pause:
  - While busy, paused=1 whenever pause=1 or door_closed=0.
  - While paused, the prescaler and secs_left hold and all actuators are 0.
  - door_lock stays 1 while paused, unless door_closed=0; then door_lock=0.
  - Resume happens in the cycle after pause=0 and door_closed=1. Counting continues from the held values; there is no restart of the phase.
- Stop: stop=1 while busy forces IDLE on the next edge. All outputs go to their reset values and done stays 0. stop takes priority over pause, a tick, or a phase end in the same cycle. Start and stop together in IDLE leave the block in IDLE.
- Illegal phase encodings (6, 7) return to IDLE on the next edge.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Normal program (CLK_PER_SEC=4, prog=0): start pulse with door closed -> FILL 28 cycles, WASH 20, RINSE 20, SPIN 40; done pulses in the first IDLE cycle, 108 cycles after FILL entry; valve/motor/spin follow the phase.
- Double wash (prog=1) -> phase sequence 1,2,3,2,3,4,0; wash_count reaches 2; done 148 cycles after FILL entry.
- Spin+dry (prog=2) -> SPIN 40 cycles then DRY 40 cycles; heater_on only in DRY; valve_on never asserted; done at cycle 80.
- Pause in WASH with secs_left=3 for 17 cycles -> secs_left and prescaler frozen, motor_on=0, door_lock=1; on release, WASH ends exactly 17 cycles later than the unpaused run.
- Door opened mid-RINSE -> paused=1, door_lock=0, actuators off. start while paused is ignored. Door closed -> resumes. Door open in IDLE: start is ignored and phase stays 0.
- Stop together with the final SPIN tick -> IDLE next cycle, done=0. Asynchronous rst mid-FILL -> all outputs 0 immediately, then a fresh start is accepted.
